exmem_skid_stage: RTL and testbench

Parametrised elastic EX/MEM pipeline register: carries the ALU result, destination register, memory/writeback control bits and the forwarded store data from EX to MEM, like the fixed EX/MEM register, but adds a synchronous reset, a valid/ready handshake with a 2-entry skid buffer, a flush that inserts a bubble, and an occupancy output. Sits between the EX stage and the MEM stage. Lets the MEM stage stall (e.g. on a slow data memory) without a combinational ready path back through EX.

---
 rtl/exmem_skid_stage.sv | 82 ++++++++
 tb/tb_exmem_skid_stage.sv | 119 +++++++++++
 2 files changed

// File: rtl/exmem_skid_stage.sv
// Elastic EX/MEM pipeline register with a 2-entry skid buffer, flush-to-bubble and occupancy.
// in_ready depends only on held state and rst, so MEM stalls never ripple combinationally into EX.
module exmem_skid_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_aluresult,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_rtdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_aluresult,
  output logic [REG_W-1:0]  out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_rtdata,
  output logic [1:0]        occupancy
);
  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rt;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state;
  entry_t mainQ, skidQ, inEnt;
  logic   mainValid, skidValid, push, pop;

  assign inEnt     = '{alu: in_aluresult, rd: in_rd, ctrl: in_ctrl, rt: in_rtdata};
  assign mainValid = (state != EMPTY);
  assign skidValid = (state == FULL);
  assign in_ready  = !skidValid && !rst;
  assign push      = in_valid && in_ready;
  assign pop       = mainValid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      mainQ <= '0;
      skidQ <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) begin
          mainQ <= inEnt;
          state <= ONE;
        end
        ONE: begin
          if (push && pop) mainQ <= inEnt;
          else if (push) begin
            skidQ <= inEnt;
            state <= FULL;
          end else if (pop) state <= EMPTY;
        end
        FULL: if (pop) begin
          mainQ <= skidQ;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid     = mainValid;
  assign out_aluresult = mainQ.alu;
  assign out_rd        = mainQ.rd;
  assign out_rtdata    = mainQ.rt;
  // A bubble must never assert MemRead/MemWrite/RegWrite, whatever stale bits main holds.
  assign out_ctrl      = mainQ.ctrl & {CTRL_W{mainValid}};
  assign occupancy     = state;
endmodule

// File: tb/tb_exmem_skid_stage.sv
// Bench for exmem_skid_stage: directed scenarios then random traffic, checked against a queue model.
module tb_exmem_skid_stage;
  localparam int DATA_W = 32, REG_W = 5, CTRL_W = 4;

  logic              clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] in_aluresult = '0, in_rtdata = '0, out_aluresult, out_rtdata;
  logic [REG_W-1:0]  in_rd = '0, out_rd;
  logic [CTRL_W-1:0] in_ctrl = '0, out_ctrl;
  logic [1:0]        occupancy;

  exmem_skid_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluresult(in_aluresult), .in_rd(in_rd), .in_ctrl(in_ctrl), .in_rtdata(in_rtdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluresult(out_aluresult),
    .out_rd(out_rd), .out_ctrl(out_ctrl), .out_rtdata(out_rtdata), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rt;
  } ent_t;

  ent_t q[$];
  int   nChecks = 0, nPass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
  endtask

  // One clock: drive inputs, check in_ready, advance model at the edge, check outputs after it.
  task automatic step(input logic r, input logic fl, input logic iv, input logic ordy,
                      input logic [DATA_W-1:0] alu, input logic [REG_W-1:0] rd,
                      input logic [CTRL_W-1:0] ctl, input logic [DATA_W-1:0] rt);
    logic expRdy, doPush, doPop;
    ent_t e;
    rst = r; flush = fl; in_valid = iv; out_ready = ordy;
    in_aluresult = alu; in_rd = rd; in_ctrl = ctl; in_rtdata = rt;
    #1;
    expRdy = (q.size() < 2) && !r;
    chk("in_ready", in_ready, expRdy);
    doPush = iv && expRdy;
    doPop  = (q.size() > 0) && ordy;
    @(posedge clk);
    if (r || fl) q.delete();
    else begin
      if (doPop) void'(q.pop_front());
      if (doPush) begin
        e.alu = alu; e.rd = rd; e.ctrl = ctl; e.rt = rt;
        q.push_back(e);
      end
    end
    #1;
    chk("out_valid", out_valid, q.size() > 0);
    chk("occupancy", occupancy, q.size());
    if (q.size() > 0) begin
      chk("out_aluresult", out_aluresult, q[0].alu);
      chk("out_rd", out_rd, q[0].rd);
      chk("out_ctrl", out_ctrl, q[0].ctrl);
      chk("out_rtdata", out_rtdata, q[0].rt);
    end else chk("out_ctrl_bubble", out_ctrl, 0);
  endtask

  initial begin
    @(negedge clk);
    // Reset held two cycles with in_valid asserted: nothing captured.
    repeat (2) step(1, 0, 1, 1, 32'hDEAD, 5'd7, 4'hF, 32'hBEEF);
    chk("rst_alu", out_aluresult, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_rt", out_rtdata, 0);
    rst = 0; in_valid = 0; #1;
    chk("rdy_after_rst", in_ready, 1);

    // Streaming at full rate.
    for (int i = 1; i <= 3; i++) step(0, 0, 1, 1, 32'(i * 16), 5'(i), 4'b0001, 32'(i + 100));
    step(0, 0, 0, 1, 0, 0, 0, 0);

    // Stall fill then drain.
    step(0, 0, 1, 0, 32'hA, 5'd10, 4'b0101, 32'h1A);
    step(0, 0, 1, 0, 32'hB, 5'd11, 4'b0011, 32'h1B);
    chk("stall_head", out_aluresult, 32'hA);
    step(0, 0, 1, 0, 32'hC, 5'd12, 4'b0001, 32'h1C);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    chk("drain_second", out_aluresult, 32'hB);
    step(0, 0, 0, 1, 0, 0, 0, 0);

    // Push and pop together while ONE.
    step(0, 0, 1, 0, 32'h5, 5'd5, 4'b0001, 32'h55);
    step(0, 0, 1, 1, 32'h6, 5'd6, 4'b0001, 32'h66);
    chk("pushpop_out", out_aluresult, 32'h6);
    step(0, 0, 0, 1, 0, 0, 0, 0);

    // Flush while FULL with a concurrent push.
    step(0, 0, 1, 0, 32'h71, 5'd1, 4'b0010, 32'h71);
    step(0, 0, 1, 0, 32'h72, 5'd2, 4'b0010, 32'h72);
    step(0, 1, 1, 0, 32'h73, 5'd3, 4'b0010, 32'h73);
    step(0, 0, 0, 1, 0, 0, 0, 0);

    // Bubble over stale ctrl 1010.
    step(0, 0, 1, 1, 32'h99, 5'd9, 4'b1010, 32'h99);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    chk("bubble_ctrl", out_ctrl, 0);

    // Random traffic, occasional flush and reset.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
           $urandom, 5'($urandom), 4'($urandom), $urandom);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
